vedic_mul16_scheduler: RTL and testbench

Sequencer that computes 16x16 products by time-sharing one pipelined 8x8 Vedic multiplier. Splits each operand pair into four 8x8 partial products and issues one per cycle to the shared multiplier. Tracks the in-flight partials through a tag delay line matched to the multiplier latency, and accumulates them into a 32-bit result. Sits between the convolution MAC front end (ready/valid) and the 8x8 multiplier instance.

---
 rtl/vedic_mul16_pkg.sv | 32 +++
 rtl/vedic_mul16_scheduler_if.sv | 25 ++
 rtl/vedic_mul16_tag_pipe.sv | 40 ++++
 rtl/vedic_mul16_scheduler.sv | 133 +++++++++++++
 tb/tb_vedic_mul16_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vedic_mul16_pkg.sv
// Shared types for the 16x16-over-8x8 Vedic multiplier scheduler.
// Holds the FSM encoding, the partial-product tag and the per-index shift table.
package vedic_mul16_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIX,
        DONE
    } state_t;

    typedef logic [1:0] pp_idx_t;

    // idx0 = AL*BL, idx1 = AL*BH, idx2 = AH*BL, idx3 = AH*BH
    localparam logic [4:0] PP_SHIFT [4] = '{5'd0, 5'd8, 5'd8, 5'd16};

    typedef struct packed {
        logic    valid;
        pp_idx_t idx;
    } tag_t;

    // |-32768| still fits because the result is read as unsigned.
    function automatic logic [15:0] magnitude(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

    function automatic logic [7:0] pp_byte(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/vedic_mul16_scheduler_if.sv
// Operand/result handshake plus the link to the shared 8x8 multiplier.
// slave = scheduler side, master = surrounding MAC front end / multiplier.
interface vedic_mul16_scheduler_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        busy;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_p,
        output in_ready, out_valid, out_p, busy, mul_a, mul_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_p,
        input  in_ready, out_valid, out_p, busy, mul_a, mul_b
    );
endinterface

// File: rtl/vedic_mul16_tag_pipe.sv
// Delay line of partial-product tags, aligned with the multiplier pipeline.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
// pending flags valid tags that have not yet reached the output stage.
module vedic_mul16_tag_pipe
    import vedic_mul16_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic pending
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | stage[i].valid;
        end
    end

endmodule

// File: rtl/vedic_mul16_scheduler.sv
// 16x16 product via four 8x8 partials time-shared on one external pipelined multiplier.
// Latency MUL_LATENCY+4 from acceptance (+1 with VEDIC_MUL16_SIGNED_EN for the sign fix-up).
// One operation at a time; DONE holds the result until out_ready.
module vedic_mul16_scheduler
    import vedic_mul16_pkg::*;
#(
    parameter int MUL_LATENCY = 5
) (
    input logic                     clk,
    input logic                     rst_n,
    vedic_mul16_scheduler_if.slave  bus
);

`ifdef VEDIC_MUL16_SIGNED_EN
    localparam state_t DRAIN_EXIT = FIX;
`else
    localparam state_t DRAIN_EXIT = DONE;
`endif

    state_t      state, state_nxt;
    pp_idx_t     idx, idx_nxt;
    logic [15:0] op_a, op_b, cap_a, cap_b;
    logic [31:0] acc, acc_nxt, pp_ext, out_p_q;
    logic [7:0]  mul_a_q, mul_b_q;
    tag_t        tag_in, tag_out;
    logic        pending;

`ifdef VEDIC_MUL16_SIGNED_EN
    logic neg;

    assign cap_a = magnitude(bus.in_a);
    assign cap_b = magnitude(bus.in_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            neg <= bus.in_a[15] ^ bus.in_b[15];
        end
    end
`else
    assign cap_a = bus.in_a;
    assign cap_b = bus.in_b;
`endif

    assign idx_nxt = idx + 2'd1;
    assign tag_in  = {state == ISSUE, idx};

    vedic_mul16_tag_pipe #(
        .DEPTH (MUL_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .pending (pending)
    );

    // mul_p is only trusted when a tag emerges alongside it.
    assign pp_ext  = {16'd0, bus.mul_p} << PP_SHIFT[tag_out.idx];
    assign acc_nxt = tag_out.valid ? acc + pp_ext : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = ISSUE;
            ISSUE:   if (idx == 2'd3)   state_nxt = DRAIN;
            DRAIN:   if (!pending)      state_nxt = DRAIN_EXIT;
            FIX:                        state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            out_p_q <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            acc <= acc_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a    <= cap_a;
                        op_b    <= cap_b;
                        acc     <= '0;
                        idx     <= '0;
                        mul_a_q <= cap_a[7:0];
                        mul_b_q <= cap_b[7:0];
                    end
                end
                ISSUE: begin
                    idx <= idx_nxt;
                    if (idx == 2'd3) begin
                        mul_a_q <= '0;
                        mul_b_q <= '0;
                    end else begin
                        mul_a_q <= pp_byte(op_a, idx_nxt[1]);
                        mul_b_q <= pp_byte(op_b, idx_nxt[0]);
                    end
                end
`ifdef VEDIC_MUL16_SIGNED_EN
                FIX: out_p_q <= neg ? (32'd0 - acc) : acc;
`else
                // Last partial lands on the same edge that leaves DRAIN.
                DRAIN: if (!pending) out_p_q <= acc_nxt;
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_p     = out_p_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_vedic_mul16_scheduler.sv
// Bench for vedic_mul16_scheduler at MUL_LATENCY 5, 1 and 15 with behavioural multipliers.
// A transaction-level model is checked every cycle; directed vectors pin it with literals.
module tb_vedic_mul16_scheduler;

`ifdef VEDIC_MUL16_SIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_g  [3];
    logic        out_ready_g [3];
    logic [15:0] in_a_g      [3];
    logic [15:0] in_b_g      [3];
    logic        in_ready_g  [3];
    logic        out_valid_g [3];
    logic        busy_g      [3];
    logic [31:0] out_p_g     [3];
    logic [7:0]  mul_a_g     [3];
    logic [7:0]  mul_b_g     [3];

    // Transaction model: busy flag, cycles since acceptance, expected product, operand magnitudes
    logic        busy_m [3];
    int          cnt_m  [3];
    logic [31:0] res_m  [3];
    logic [15:0] ma_m   [3];
    logic [15:0] mb_m   [3];

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 5 : ((d == 1) ? 1 : 15);
    endfunction

    function automatic int res_lat(input int d);
        return lat_of(d) + 4 + EXTRA;
    endfunction

    function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b);
`ifdef VEDIC_MUL16_SIGNED_EN
        logic signed [31:0] sa, sb;
        sa = 32'($signed(a));
        sb = 32'($signed(b));
        return 32'(sa * sb);
`else
        return {16'd0, a} * {16'd0, b};
`endif
    endfunction

    function automatic logic [15:0] mag(input logic [15:0] v);
`ifdef VEDIC_MUL16_SIGNED_EN
        if (v[15]) return 16'd0 - v;
`endif
        return v;
    endfunction

    function automatic logic issuing(input int d);
        return busy_m[d] && (cnt_m[d] <= 3);
    endfunction

    // Cycle k of an operation carries partial k: A high for k>=2, B high for odd k.
    function automatic logic [7:0] exp_mul(input int d, input bit is_b);
        if (!issuing(d)) return 8'd0;
        if (is_b) return (cnt_m[d] % 2 == 1) ? mb_m[d][15:8] : mb_m[d][7:0];
        return (cnt_m[d] >= 2) ? ma_m[d][15:8] : ma_m[d][7:0];
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L = (g == 0) ? 5 : ((g == 1) ? 1 : 15);

        vedic_mul16_scheduler_if bus ();

        logic [15:0] prod_q [L];
        logic        iss_q  [L];
        logic [15:0] junk;

        assign bus.in_valid  = in_valid_g[g];
        assign bus.out_ready = out_ready_g[g];
        assign bus.in_a      = in_a_g[g];
        assign bus.in_b      = in_b_g[g];
        assign in_ready_g[g]  = bus.in_ready;
        assign out_valid_g[g] = bus.out_valid;
        assign busy_g[g]      = bus.busy;
        assign out_p_g[g]     = bus.out_p;
        assign mul_a_g[g]     = bus.mul_a;
        assign mul_b_g[g]     = bus.mul_b;

        // Pipelined 8x8 multiplier; returns noise in slots that carry no issued partial.
        always @(posedge clk) begin
            junk      <= 16'($urandom);
            prod_q[0] <= 16'(bus.mul_a) * 16'(bus.mul_b);
            iss_q[0]  <= issuing(g);
            for (int i = 1; i < L; i++) begin
                prod_q[i] <= prod_q[i-1];
                iss_q[i]  <= iss_q[i-1];
            end
        end
        assign bus.mul_p = iss_q[L-1] ? prod_q[L-1] : junk;

        vedic_mul16_scheduler #(
            .MUL_LATENCY (L)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                busy_m[d] <= 1'b0;
                cnt_m[d]  <= 0;
            end else if (!busy_m[d]) begin
                if (in_valid_g[d]) begin
                    busy_m[d] <= 1'b1;
                    cnt_m[d]  <= 0;
                    res_m[d]  <= golden(in_a_g[d], in_b_g[d]);
                    ma_m[d]   <= mag(in_a_g[d]);
                    mb_m[d]   <= mag(in_b_g[d]);
                end
            end else if (cnt_m[d] >= res_lat(d)) begin
                if (out_ready_g[d]) busy_m[d] <= 1'b0;
            end else begin
                cnt_m[d] <= cnt_m[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic ov_exp;
            ov_exp = busy_m[d] && (cnt_m[d] >= res_lat(d));
            check("in_ready",  d, 32'(in_ready_g[d]),  32'(!busy_m[d]));
            check("out_valid", d, 32'(out_valid_g[d]), 32'(ov_exp));
            check("busy",      d, 32'(busy_g[d]),      32'(busy_m[d]));
            check("mul_a",     d, 32'(mul_a_g[d]),     32'(exp_mul(d, 1'b0)));
            check("mul_b",     d, 32'(mul_b_g[d]),     32'(exp_mul(d, 1'b1)));
            if (!rst_n) check("out_p_reset", d, out_p_g[d], 32'd0);
            else if (ov_exp) check("out_p", d, out_p_g[d], res_m[d]);
        end
    end

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] lit, input int edge_exp, input bit chk_seq);
        int n, e;
        logic [7:0] seq [4];
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h34, 8'h34, 8'h12, 8'h12};
        seq     = '{8'h00, 8'h00, 8'h00, 8'h00};
        @(posedge clk); #1;
        in_a_g[d] = a;
        in_b_g[d] = b;
        in_valid_g[d] = 1'b1;
        n = 0;
        while (!in_ready_g[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid_g[d] = 1'b0;
        e = 0;
        while (!out_valid_g[d] && e < 40) begin
            if (e < 4) seq[e] = mul_a_g[d];
            @(posedge clk); #1;
            e++;
        end
        check("result_edge",  d, 32'(e), 32'(edge_exp));
        check("result_value", d, out_p_g[d], lit);
        if (chk_seq) begin
            for (int k = 0; k < 4; k++) check("mul_a_seq", d, 32'(seq[k]), 32'(exp_seq[k]));
        end
    endtask

    initial begin
        int accepted, guard, n;
        logic rdy;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid_g[d]  = 1'b0;
            out_ready_g[d] = 1'b1;
            in_a_g[d]      = 16'd0;
            in_b_g[d]      = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  0, 32'(in_ready_g[0]),  32'd1);
        check("rst_out_valid", 0, 32'(out_valid_g[0]), 32'd0);
        check("rst_busy",      0, 32'(busy_g[0]),      32'd0);
        check("rst_out_p",     0, out_p_g[0],          32'd0);
        check("rst_mul_a",     0, 32'(mul_a_g[0]),     32'd0);
        rst_n = 1'b1;

        run_op(0, 16'h1234, 16'h5678, 32'h0626_0060, 9 + EXTRA, 1'b1);
`ifdef VEDIC_MUL16_SIGNED_EN
        run_op(0, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 10, 1'b0);
        run_op(0, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 10, 1'b0);
        run_op(0, 16'h8000, 16'h8000, 32'h4000_0000, 10, 1'b0);
        run_op(0, 16'h8000, 16'h0001, 32'hFFFF_8000, 10, 1'b0);
        run_op(2, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 20, 1'b0);
`else
        run_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 9, 1'b0);
        run_op(2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 19, 1'b0);
`endif
        run_op(0, 16'h0000, 16'hABCD, 32'h0000_0000, 9 + EXTRA, 1'b0);
        run_op(1, 16'h1234, 16'h5678, 32'h0626_0060, 5 + EXTRA, 1'b0);

        // in_valid held high, random backpressure
        @(posedge clk); #1;
        in_a_g[0] = rnd16();
        in_b_g[0] = rnd16();
        in_valid_g[0] = 1'b1;
        accepted = 0;
        guard = 0;
        while (accepted < 100 && guard < 20000) begin
            out_ready_g[0] = 1'($urandom_range(0, 1));
            rdy = in_ready_g[0];
            @(posedge clk); #1;
            guard++;
            if (rdy) begin
                accepted++;
                in_a_g[0] = rnd16();
                in_b_g[0] = rnd16();
            end
        end
        in_valid_g[0]  = 1'b0;
        out_ready_g[0] = 1'b1;
        check("random_ops_done", 0, 32'(accepted), 32'd100);

        // reset in the middle of an operation
        n = 0;
        while (!in_ready_g[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_a_g[0] = 16'hBEEF;
        in_b_g[0] = 16'h1357;
        in_valid_g[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_g[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_reset", 0, 32'(busy_g[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  0, 32'(in_ready_g[0]),  32'd1);
        check("midrst_out_valid", 0, 32'(out_valid_g[0]), 32'd0);
        check("midrst_busy",      0, 32'(busy_g[0]),      32'd0);
        check("midrst_out_p",     0, out_p_g[0],          32'd0);
        check("midrst_mul_a",     0, 32'(mul_a_g[0]),     32'd0);
        check("midrst_mul_b",     0, 32'(mul_b_g[0]),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(0, 16'h0003, 16'h0004, 32'h0000_000C, 9 + EXTRA, 1'b0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
